regfile_writeback: RTL and testbench

Write-side front end for the integer register file. It buffers results from two producers, the single-cycle ALU and the multi-cycle LSU, in an in-order FIFO. It drains one result per cycle onto the register file write port (reg_write/w_addr/w_data). It also keeps a per-register busy scoreboard so decode can stall on registers with a write still pending.

---
 rtl/regfile_writeback.sv | 179 +++++++++++++++++
 tb/tb_regfile_writeback.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side front end of the integer register file.
// ALU and LSU results are buffered in an in-order FIFO. The FIFO drains one entry
// per cycle onto the registered write port (reg_write/w_addr/w_data). A per-register
// busy scoreboard lets decode stall on registers that still have a write pending.
// Optional feature macro: WB_BYPASS_EN adds commit-cycle forwarding for rs1/rs2.
// Data width comes from `MXLEN. A default of 32 is used when it is not already defined.

`ifndef MXLEN
`define MXLEN 32
`endif

module regfile_writeback #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned REG_NUM = 32
) (
   input  logic              CLK,
   input  logic              RST,
   // ALU producer
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [4:0]        alu_rd,
   input  logic [`MXLEN-1:0] alu_data,
   // LSU producer
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [4:0]        lsu_rd,
   input  logic [`MXLEN-1:0] lsu_data,
   // Issue marks a destination register busy
   input  logic              iss_valid,
   input  logic [4:0]        iss_rd,
   // Decode queries
   input  logic [4:0]        chk_rs1,
   input  logic [4:0]        chk_rs2,
   input  logic [4:0]        chk_rd,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rd_busy,
`ifdef WB_BYPASS_EN
   output logic              rs1_fwd_valid,
   output logic [`MXLEN-1:0] rs1_fwd_data,
   output logic              rs2_fwd_valid,
   output logic [`MXLEN-1:0] rs2_fwd_data,
`endif
   // Register file write port
   output logic              reg_write,
   output logic [4:0]        w_addr,
   output logic [`MXLEN-1:0] w_data
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] ALU_LIM = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LSU_LIM = CW'(DEPTH - 2);

   // FIFO storage and bookkeeping
   logic [4:0]        rd_mem   [DEPTH];
   logic [`MXLEN-1:0] data_mem [DEPTH];

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] lsu_slot;

   logic alu_push;
   logic lsu_push;
   logic pop;

   logic [REG_NUM-1:0] busy_q, busy_d;

   // Readiness looks only at the registered count, so a same-cycle pop earns no credit.
   // LSU needs two free slots because it may land behind an ALU push in the same cycle.
   always_comb begin
      alu_ready = (count_q <= ALU_LIM);
      lsu_ready = (count_q <= LSU_LIM);
   end

   // Handshakes to x0 complete but never occupy a FIFO slot.
   always_comb begin
      alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
      lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
      pop      = (count_q != '0);
      lsu_slot = wr_ptr_q + PW'(alu_push);
      wr_ptr_d = wr_ptr_q + PW'(alu_push) + PW'(lsu_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(alu_push) + CW'(lsu_push) - CW'(pop);
   end

   // FIFO pointer and occupancy state
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO payload; ALU lands first, LSU right behind it.
   always_ff @(posedge CLK) begin
      if (alu_push) begin
         rd_mem[wr_ptr_q]   <= alu_rd;
         data_mem[wr_ptr_q] <= alu_data;
      end
      if (lsu_push) begin
         rd_mem[lsu_slot]   <= lsu_rd;
         data_mem[lsu_slot] <= lsu_data;
      end
   end

   // Pop the head onto the write port; address/data hold when the FIFO is empty.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         reg_write <= 1'b0;
         w_addr    <= 5'd0;
         w_data    <= '0;
      end else begin
         reg_write <= pop;
         if (pop) begin
            w_addr <= rd_mem[rd_ptr_q];
            w_data <= data_mem[rd_ptr_q];
         end
      end
   end

   // Scoreboard next state: clear at the commit edge, then set on issue so a
   // coincident set wins. x0 is never busy.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < REG_NUM; r++) begin
         if (reg_write && (w_addr == 5'(r))) begin
            busy_d[r] = 1'b0;
         end
         if (iss_valid && (iss_rd == 5'(r))) begin
            busy_d[r] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Scoreboard state
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

`ifdef WB_BYPASS_EN
   logic rs1_hit;
   logic rs2_hit;

   // During the commit cycle the register file still returns the old value, so
   // forward the write port and report the source as not busy.
   always_comb begin
      rs1_hit       = reg_write && (w_addr == chk_rs1) && (chk_rs1 != 5'd0);
      rs2_hit       = reg_write && (w_addr == chk_rs2) && (chk_rs2 != 5'd0);
      rs1_fwd_valid = rs1_hit;
      rs2_fwd_valid = rs2_hit;
      rs1_fwd_data  = w_data;
      rs2_fwd_data  = w_data;
      rs1_busy      = busy_q[chk_rs1] && !rs1_hit;
      rs2_busy      = busy_q[chk_rs2] && !rs2_hit;
      rd_busy       = busy_q[chk_rd];
   end
`else
   // Plain scoreboard lookups; sources stay busy through the commit cycle.
   always_comb begin
      rs1_busy = busy_q[chk_rs1];
      rs2_busy = busy_q[chk_rs2];
      rd_busy  = busy_q[chk_rd];
   end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a queue-level reference model predicts
// the write stream and scoreboard state; a negedge monitor compares against the DUT.

`ifndef MXLEN
`define MXLEN 32
`endif

module tb_regfile_writeback;

   localparam int DEPTH = 4;
   localparam int XLEN  = `MXLEN;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } wb_t;

   logic            CLK;
   logic            RST;
   logic            alu_valid, alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid, lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic [4:0]      chk_rs1, chk_rs2, chk_rd;
   logic            rs1_busy, rs2_busy, rd_busy;
   logic            reg_write;
   logic [4:0]      w_addr;
   logic [XLEN-1:0] w_data;
`ifdef WB_BYPASS_EN
   logic            rs1_fwd_valid, rs2_fwd_valid;
   logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

   regfile_writeback #(.DEPTH(DEPTH), .REG_NUM(32)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .lsu_valid     (lsu_valid),
      .lsu_ready     (lsu_ready),
      .lsu_rd        (lsu_rd),
      .lsu_data      (lsu_data),
      .iss_valid     (iss_valid),
      .iss_rd        (iss_rd),
      .chk_rs1       (chk_rs1),
      .chk_rs2       (chk_rs2),
      .chk_rd        (chk_rd),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .rd_busy       (rd_busy),
`ifdef WB_BYPASS_EN
      .rs1_fwd_valid (rs1_fwd_valid),
      .rs1_fwd_data  (rs1_fwd_data),
      .rs2_fwd_valid (rs2_fwd_valid),
      .rs2_fwd_data  (rs2_fwd_data),
`endif
      .reg_write     (reg_write),
      .w_addr        (w_addr),
      .w_data        (w_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model state
   wb_t             fifo_m[$];
   wb_t             exp_q[$];
   bit [31:0]       busy_m;
   bit              m_wr_valid;
   logic [4:0]      m_wr_addr;
   logic [XLEN-1:0] m_wr_data;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      fifo_m.delete();
      exp_q.delete();
      busy_m     = '0;
      m_wr_valid = 1'b0;
      m_wr_addr  = 5'd0;
      m_wr_data  = '0;
   endtask

   // One clock edge of the reference: inputs are those held during the ending cycle.
   task automatic model_step();
      int  n;
      bit  acc_alu, acc_lsu;
      wb_t e;
      n       = fifo_m.size();
      acc_alu = alu_valid && (n <= DEPTH - 1);
      acc_lsu = lsu_valid && (n <= DEPTH - 2);
      if (m_wr_valid) busy_m[m_wr_addr] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) busy_m[iss_rd] = 1'b1;
      if (n > 0) begin
         e = fifo_m.pop_front();
         exp_q.push_back(e);
         m_wr_valid = 1'b1;
         m_wr_addr  = e.rd;
         m_wr_data  = e.data;
      end else begin
         m_wr_valid = 1'b0;
      end
      if (acc_alu && alu_rd != 5'd0) fifo_m.push_back('{rd: alu_rd, data: alu_data});
      if (acc_lsu && lsu_rd != 5'd0) fifo_m.push_back('{rd: lsu_rd, data: lsu_data});
   endtask

   function automatic bit exp_busy(input logic [4:0] r, input bit is_src);
      bit b;
      b = busy_m[r];
`ifdef WB_BYPASS_EN
      if (is_src && m_wr_valid && m_wr_addr == r && r != 5'd0) b = 1'b0;
`else
      if (is_src) b = busy_m[r];
`endif
      return b;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a write.
   always @(negedge CLK) begin
      wb_t e;
      check("reg_write", reg_write, m_wr_valid);
      check("w_addr", w_addr, m_wr_addr);
      check("w_data", w_data, m_wr_data);
      if (reg_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("order_addr", w_addr, e.rd);
            check("order_data", w_data, e.data);
         end
      end
      check("alu_ready", alu_ready, fifo_m.size() <= DEPTH - 1);
      check("lsu_ready", lsu_ready, fifo_m.size() <= DEPTH - 2);
      check("rs1_busy", rs1_busy, exp_busy(chk_rs1, 1'b1));
      check("rs2_busy", rs2_busy, exp_busy(chk_rs2, 1'b1));
      check("rd_busy", rd_busy, exp_busy(chk_rd, 1'b0));
`ifdef WB_BYPASS_EN
      check("rs1_fwd_valid", rs1_fwd_valid,
            m_wr_valid && m_wr_addr == chk_rs1 && chk_rs1 != 5'd0);
      check("rs2_fwd_valid", rs2_fwd_valid,
            m_wr_valid && m_wr_addr == chk_rs2 && chk_rs2 != 5'd0);
      if (rs1_fwd_valid === 1'b1) check("rs1_fwd_data", rs1_fwd_data, m_wr_data);
      if (rs2_fwd_valid === 1'b1) check("rs2_fwd_data", rs2_fwd_data, m_wr_data);
`endif
   end

   // Advance one edge; new inputs are driven 2 time units after it.
   task automatic cycle();
      @(posedge CLK);
      if (!RST) model_step();
      #2;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      iss_valid = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      model_clear();
      cycle();
      cycle();
      RST = 1'b0;
   endtask

   initial begin
      RST       = 1'b1;
      alu_rd    = '0;
      alu_data  = '0;
      lsu_rd    = '0;
      lsu_data  = '0;
      iss_rd    = '0;
      chk_rs1   = '0;
      chk_rs2   = '0;
      chk_rd    = '0;
      idle_inputs();
      model_clear();
      cycle();
      check("rst_reg_write", reg_write, 0);
      check("rst_alu_ready", alu_ready, 1);
      cycle();
      RST = 1'b0;

      // Single write: accepted at edge N, visible N+1..N+2
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      idle_inputs();
      check("single_pre", reg_write, 0);
      cycle();
      check("single_we", reg_write, 1);
      check("single_addr", w_addr, 5);
      check("single_data", w_data, 32'hDEADBEEF);
      cycle();
      check("single_off", reg_write, 0);
      check("single_hold", w_addr, 5);

      // Dual push: x1 then x2
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
      cycle();
      idle_inputs();
      cycle();
      check("dual_first", w_addr, 1);
      cycle();
      check("dual_second", w_addr, 2);
      check("dual_second_data", w_data, 32'h22);
      cycle();
      check("dual_drained", reg_write, 0);
      check("dual_ready", lsu_ready, 1);

      // x0 results are accepted but never written
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      check("x0_ready", alu_ready, 1);
      cycle();
      idle_inputs();
      cycle();
      check("x0_no_write", reg_write, 0);

      // Busy tracking for x7 until its commit edge
      chk_rs1 = 5'd7; chk_rs2 = 5'd9; chk_rd = 5'd7;
      iss_valid = 1'b1; iss_rd = 5'd7;
      cycle();
      idle_inputs();
      check("x7_busy", rs1_busy, 1);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      cycle();
      idle_inputs();
      cycle();
`ifdef WB_BYPASS_EN
      check("x7_commit_cycle", rs1_busy, 0);
`else
      check("x7_commit_cycle", rs1_busy, 1);
`endif
      check("x7_rd_busy", rd_busy, 1);
      cycle();
      check("x7_cleared", rs1_busy, 0);

      // Issue to x7 on the very edge x7 commits: set wins
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
      cycle();
      idle_inputs();
      cycle();
      iss_valid = 1'b1; iss_rd = 5'd7;
      cycle();
      idle_inputs();
      check("x7_set_wins", rs1_busy, 1);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h79;
      cycle();
      idle_inputs();
      repeat (3) cycle();
      check("x7_final_clear", rs1_busy, 0);

      // Commit x9 while decode looks at rs2=x9
      iss_valid = 1'b1; iss_rd = 5'd9;
      cycle();
      idle_inputs();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h1234;
      cycle();
      idle_inputs();
      cycle();
`ifdef WB_BYPASS_EN
      check("x9_busy_bypass", rs2_busy, 0);
      check("x9_fwd_valid", rs2_fwd_valid, 1);
      check("x9_fwd_data", rs2_fwd_data, 32'h1234);
`else
      check("x9_busy_nobypass", rs2_busy, 1);
`endif
      cycle();
      check("x9_cleared", rs2_busy, 0);

      // Reset mid-operation with three entries buffered
      iss_valid = 1'b1; iss_rd = 5'd12;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
      cycle();
      iss_valid = 1'b0;
      alu_rd = 5'd5; alu_data = 32'h55;
      lsu_rd = 5'd6; lsu_data = 32'h66;
      cycle();
      idle_inputs();
      chk_rd = 5'd12;
      check("pre_rst_lsu_ready", lsu_ready, 0);
      do_reset();
      check("mid_rst_we", reg_write, 0);
      check("mid_rst_addr", w_addr, 0);
      check("mid_rst_data", w_data, 0);
      check("mid_rst_busy", rd_busy, 0);
      check("mid_rst_alu_ready", alu_ready, 1);
      check("mid_rst_lsu_ready", lsu_ready, 1);
      repeat (4) cycle();

      // Backpressure: both producers always valid
      for (int i = 0; i < 24; i++) begin
         alu_valid = 1'b1; alu_rd = 5'($urandom_range(31, 1)); alu_data = $urandom;
         lsu_valid = 1'b1; lsu_rd = 5'($urandom_range(31, 1)); lsu_data = $urandom;
         cycle();
      end
      idle_inputs();
      repeat (6) cycle();

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         alu_valid = ($urandom_range(99) < 60);
         alu_rd    = 5'($urandom_range(15));
         alu_data  = $urandom;
         lsu_valid = ($urandom_range(99) < 40);
         lsu_rd    = 5'($urandom_range(15));
         lsu_data  = $urandom;
         iss_valid = ($urandom_range(99) < 15);
         iss_rd    = 5'($urandom_range(15));
         chk_rs1   = 5'($urandom_range(15));
         chk_rs2   = 5'($urandom_range(15));
         chk_rd    = 5'($urandom_range(15));
         if (i == 1000) do_reset();
         cycle();
      end
      idle_inputs();
      repeat (8) cycle();
      check("drained_scoreboard", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
